// File: rtl/pwm_multi_pkg.sv
// Shared definitions for the multi-channel PWM controller: default sizing,
// the per-channel mode bits, the center-mode count direction and a helper
// that sizes the channel-select field.
// Optional feature macro: PWM_CENTER_EN (center-aligned counting).
package pwm_multi_pkg;

    localparam int DEF_NCH     = 4;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_PRESC_W = 8;

    // Mode bits of one channel; period/duty widths depend on CNT_W and are
    // added by the channel's own config struct.
    typedef struct packed {
        logic en;
        logic center;
    } ch_mode_t;

    // Count direction for center-aligned channels.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Channel-select width; a single channel still needs one select bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow and active config, period counter, pending flag
// and the output compare. New settings move from shadow to active only at
// the end of a period, or at once when the channel is disabled or idle.
// Optional feature macro: PWM_CENTER_EN adds up/down counting.
module pwm_channel
    import pwm_multi_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             wr,
    input  logic             wr_en,
    input  logic             wr_center,
    input  logic [CNT_W-1:0] wr_period,
    input  logic [CNT_W-1:0] wr_duty,
    output logic             pending,
    output logic             pwm_out,
    output logic             cycle_start
);

    typedef struct packed {
        ch_mode_t         mode;
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] duty;
    } ch_cfg_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    ch_cfg_t          shadow_q;
    ch_cfg_t          active_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;
    logic             end_of_period;
    logic             running;
    logic             commit;

`ifdef PWM_CENTER_EN
    dir_e             dir_q;
    dir_e             dir_next;
`else
    // Edge-only build: the stored center bit has no effect.
    logic             unused_center;
    assign unused_center = active_q.mode.center;
`endif

    assign running = active_q.mode.en && (active_q.period != '0);
    assign commit  = pending && (!running || (tick && end_of_period));

    // Next counter value and end-of-period detection for the active mode
    always_comb begin
        cnt_next      = cnt_q;
        end_of_period = 1'b0;
`ifdef PWM_CENTER_EN
        dir_next      = dir_q;
        if (active_q.mode.center) begin
            if (dir_q == DIR_UP) begin
                if (cnt_q < active_q.period) begin
                    cnt_next = cnt_q + ONE;
                end else if (cnt_q <= ONE) begin
                    end_of_period = 1'b1;
                end else begin
                    dir_next = DIR_DOWN;
                    cnt_next = cnt_q - ONE;
                end
            end else if (cnt_q <= ONE) begin
                end_of_period = 1'b1;
            end else begin
                cnt_next = cnt_q - ONE;
            end
        end else
`endif
        if (cnt_q == active_q.period - ONE) begin
            end_of_period = 1'b1;
        end else begin
            cnt_next = cnt_q + ONE;
        end
    end

    // Config capture, shadow-to-active commit, counting and registered output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q    <= '0;
            active_q    <= '0;
            cnt_q       <= '0;
            pending     <= 1'b0;
            pwm_out     <= 1'b0;
            cycle_start <= 1'b0;
`ifdef PWM_CENTER_EN
            dir_q       <= DIR_UP;
`endif
        end else begin
            cycle_start <= 1'b0;
            pwm_out     <= running && (cnt_q < active_q.duty);
            if (commit) begin
                active_q    <= shadow_q;
                cnt_q       <= '0;
                pending     <= 1'b0;
                cycle_start <= 1'b1;
`ifdef PWM_CENTER_EN
                dir_q       <= DIR_UP;
`endif
            end else if (!running) begin
                cnt_q <= '0;
`ifdef PWM_CENTER_EN
                dir_q <= DIR_UP;
`endif
            end else if (tick) begin
                if (end_of_period) begin
                    cnt_q       <= '0;
                    cycle_start <= 1'b1;
`ifdef PWM_CENTER_EN
                    dir_q       <= DIR_UP;
`endif
                end else begin
                    cnt_q <= cnt_next;
`ifdef PWM_CENTER_EN
                    dir_q <= dir_next;
`endif
                end
            end
            if (wr) begin
                shadow_q.mode.en     <= wr_en;
                shadow_q.mode.center <= wr_center;
                shadow_q.period      <= wr_period;
                shadow_q.duty        <= wr_duty;
                pending              <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM controller top: shared prescaler, config-port decode
// with duty clamping and error reporting, and one pwm_channel per output.
// Optional feature macro: PWM_CENTER_EN (center-aligned channels); without
// it cfg_center is accepted on the port but always stored as 0.
module pwm_multi_ctrl
    import pwm_multi_pkg::*;
#(
    parameter  int NCH     = DEF_NCH,
    parameter  int CNT_W   = DEF_CNT_W,
    parameter  int PRESC_W = DEF_PRESC_W,
    localparam int CH_W    = ch_width(NCH)
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [PRESC_W-1:0] presc,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic               cfg_en,
    input  logic               cfg_center,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_duty,
    output logic               cfg_err,
    output logic [NCH-1:0]     pwm_out,
    output logic [NCH-1:0]     cycle_start
);

    logic [PRESC_W-1:0] pcnt_q;
    logic [PRESC_W-1:0] presc_q;
    logic               tick;
    logic [31:0]        ch_idx;
    logic               ch_ok;
    logic               accept;
    logic               clamp;
    logic [CNT_W-1:0]   duty_eff;
    logic               wr_center;
    logic [NCH-1:0]     wr;
    logic [NCH-1:0]     pending;

    assign tick     = (pcnt_q == presc_q);
    assign ch_idx   = 32'(cfg_ch);
    assign ch_ok    = (ch_idx < 32'(NCH));
    assign accept   = cfg_valid && cfg_ready && ch_ok;
    assign clamp    = (cfg_duty > cfg_period);
    assign duty_eff = clamp ? cfg_period : cfg_duty;

`ifdef PWM_CENTER_EN
    assign wr_center = cfg_center;
`else
    logic unused_center;
    assign unused_center = cfg_center;
    assign wr_center     = 1'b0;
`endif

    // Prescaler: the divide ratio is only picked up at a wrap so a rate
    // change never produces a short or long tick interval mid-count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q  <= '0;
            presc_q <= '0;
        end else if (tick) begin
            pcnt_q  <= '0;
            presc_q <= presc;
        end else begin
            pcnt_q  <= pcnt_q + 1'b1;
        end
    end

    // Ready mirrors the target channel's pending flag; out-of-range
    // channels are always ready so the bad write is taken and reported
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (ch_idx == 32'(i)) begin
                cfg_ready = ~pending[i];
            end
        end
    end

    // One-hot write strobe towards the addressed channel
    always_comb begin
        wr = '0;
        for (int i = 0; i < NCH; i++) begin
            wr[i] = accept && (ch_idx == 32'(i));
        end
    end

    // Error pulse for a bad channel number or a clamped duty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_valid && (!ch_ok || (accept && clamp));
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pwm_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .wr         (wr[g]),
            .wr_en      (cfg_en),
            .wr_center  (wr_center),
            .wr_period  (cfg_period),
            .wr_duty    (duty_eff),
            .pending    (pending[g]),
            .pwm_out    (pwm_out[g]),
            .cycle_start(cycle_start[g])
        );
    end

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Directed bench for pwm_multi_ctrl with three channels, so that channel
// number 3 is representable and out of range.
// Optional feature macro: PWM_CENTER_EN selects the center-mode expectations.
module tb_pwm_multi_ctrl;
    import pwm_multi_pkg::*;

    localparam int NCH     = 3;
    localparam int CNT_W   = 16;
    localparam int PRESC_W = 8;
    localparam int CH_W    = ch_width(NCH);

    logic               clk = 1'b0;
    logic               rst;
    logic [PRESC_W-1:0] presc;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CH_W-1:0]    cfg_ch;
    logic               cfg_en;
    logic               cfg_center;
    logic [CNT_W-1:0]   cfg_period;
    logic [CNT_W-1:0]   cfg_duty;
    logic               cfg_err;
    logic [NCH-1:0]     pwm_out;
    logic [NCH-1:0]     cycle_start;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_multi_ctrl #(
        .NCH    (NCH),
        .CNT_W  (CNT_W),
        .PRESC_W(PRESC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .presc      (presc),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_en     (cfg_en),
        .cfg_center (cfg_center),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .cfg_err    (cfg_err),
        .pwm_out    (pwm_out),
        .cycle_start(cycle_start)
    );

    always #5 clk = ~clk;

    // Drives one write for a single clock, starting at the next falling edge.
    // Returns at the falling edge right after the accepting rising edge.
    task automatic write_cfg(input int ch, input logic en, input logic center,
                             input int period, input int duty,
                             output logic ready_seen, output logic err_seen);
        @(negedge clk);
        cfg_ch     = CH_W'(ch);
        cfg_en     = en;
        cfg_center = center;
        cfg_period = CNT_W'(period);
        cfg_duty   = CNT_W'(duty);
        cfg_valid  = 1'b1;
        #1 ready_seen = cfg_ready;
        @(negedge clk);
        err_seen  = cfg_err;
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (pwm_out !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_pwm: got %b expected 000", pwm_out); end
        n_checks++;
        if (cycle_start !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_cs: got %b expected 000", cycle_start); end
        n_checks++;
        if (cfg_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b expected 0", cfg_err); end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (pwm_out !== 3'b000) begin n_fail++; $display("[TB] FAIL idle_pwm[%0d]: got %b expected 000", k, pwm_out); end
        end
        n_checks++;
        if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", cfg_ready); end
    endtask

    task automatic test_edge_basic();
        logic r, e, exp_p, exp_c;
        write_cfg(0, 1'b1, 1'b0, 10, 3, r, e);
        n_checks++;
        if (r !== 1'b1) begin n_fail++; $display("[TB] FAIL edge_ready: got %b expected 1", r); end
        n_checks++;
        if (e !== 1'b0) begin n_fail++; $display("[TB] FAIL edge_err: got %b expected 0", e); end
        @(negedge clk);
        n_checks++;
        if (cycle_start[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL edge_commit: got %b expected 1", cycle_start[0]); end
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            exp_p = ((j % 10) < 3);
            exp_c = ((j % 10) == 9);
            n_checks++;
            if (pwm_out[0] !== exp_p) begin n_fail++; $display("[TB] FAIL edge_pwm[%0d]: got %b expected %b", j, pwm_out[0], exp_p); end
            n_checks++;
            if (cycle_start[0] !== exp_c) begin n_fail++; $display("[TB] FAIL edge_cs[%0d]: got %b expected %b", j, cycle_start[0], exp_c); end
        end
    endtask

    task automatic test_duty_update();
        logic r, e, exp_p, exp_c, exp_r;
        write_cfg(1, 1'b1, 1'b0, 8, 2, r, e);
        n_checks++;
        if (r !== 1'b1) begin n_fail++; $display("[TB] FAIL upd_ready0: got %b expected 1", r); end
        for (int j = 1; j <= 17; j++) begin
            @(negedge clk);
            if (j == 1)       exp_p = 1'b0;
            else if (j <= 9)  exp_p = ((j - 2) < 2);
            else              exp_p = ((j - 10) < 6);
            exp_c = (j == 1) || (j == 9) || (j == 17);
            n_checks++;
            if (pwm_out[1] !== exp_p) begin n_fail++; $display("[TB] FAIL upd_pwm[%0d]: got %b expected %b", j, pwm_out[1], exp_p); end
            n_checks++;
            if (cycle_start[1] !== exp_c) begin n_fail++; $display("[TB] FAIL upd_cs[%0d]: got %b expected %b", j, cycle_start[1], exp_c); end
            if (j >= 5 && j <= 12) begin
                exp_r = (j >= 9);
                n_checks++;
                if (cfg_ready !== exp_r) begin n_fail++; $display("[TB] FAIL upd_ready[%0d]: got %b expected %b", j, cfg_ready, exp_r); end
            end
            if (j == 5) begin
                n_checks++;
                if (cfg_err !== 1'b0) begin n_fail++; $display("[TB] FAIL upd_err: got %b expected 0", cfg_err); end
                cfg_valid = 1'b0;
            end
            if (j == 4) begin
                cfg_ch     = CH_W'(1);
                cfg_en     = 1'b1;
                cfg_center = 1'b0;
                cfg_period = CNT_W'(8);
                cfg_duty   = CNT_W'(6);
                cfg_valid  = 1'b1;
            end
        end
    endtask

    task automatic test_duty_limits();
        logic r, e;
        write_cfg(2, 1'b1, 1'b0, 5, 0, r, e);
        n_checks++;
        if (e !== 1'b0) begin n_fail++; $display("[TB] FAIL lim0_err: got %b expected 0", e); end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_checks++;
            if (pwm_out[2] !== 1'b0) begin n_fail++; $display("[TB] FAIL lim0_pwm[%0d]: got %b expected 0", k, pwm_out[2]); end
        end
        write_cfg(2, 1'b1, 1'b0, 5, 5, r, e);
        n_checks++;
        if (r !== 1'b1) begin n_fail++; $display("[TB] FAIL lim100_ready: got %b expected 1", r); end
        n_checks++;
        if (e !== 1'b0) begin n_fail++; $display("[TB] FAIL lim100_err: got %b expected 0", e); end
        repeat (7) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (pwm_out[2] !== 1'b1) begin n_fail++; $display("[TB] FAIL lim100_pwm[%0d]: got %b expected 1", k, pwm_out[2]); end
        end
        write_cfg(2, 1'b1, 1'b0, 5, 0, r, e);
        repeat (7) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (pwm_out[2] !== 1'b0) begin n_fail++; $display("[TB] FAIL limlow_pwm[%0d]: got %b expected 0", k, pwm_out[2]); end
        end
        write_cfg(2, 1'b1, 1'b0, 5, 9, r, e);
        n_checks++;
        if (e !== 1'b1) begin n_fail++; $display("[TB] FAIL clamp_err: got %b expected 1", e); end
        @(negedge clk);
        n_checks++;
        if (cfg_err !== 1'b0) begin n_fail++; $display("[TB] FAIL clamp_err_pulse: got %b expected 0", cfg_err); end
        repeat (6) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (pwm_out[2] !== 1'b1) begin n_fail++; $display("[TB] FAIL clamp_pwm[%0d]: got %b expected 1", k, pwm_out[2]); end
        end
    endtask

    task automatic test_bad_channel();
        logic r, e;
        write_cfg(3, 1'b0, 1'b0, 0, 0, r, e);
        n_checks++;
        if (r !== 1'b1) begin n_fail++; $display("[TB] FAIL bad_ready: got %b expected 1", r); end
        n_checks++;
        if (e !== 1'b1) begin n_fail++; $display("[TB] FAIL bad_err: got %b expected 1", e); end
        @(negedge clk);
        n_checks++;
        if (cfg_err !== 1'b0) begin n_fail++; $display("[TB] FAIL bad_err_pulse: got %b expected 0", cfg_err); end
        for (int i = 0; i < NCH; i++) begin
            cfg_ch = CH_W'(i);
            #1;
            n_checks++;
            if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bad_pending[%0d]: got ready %b expected 1", i, cfg_ready); end
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (pwm_out[2] !== 1'b1) begin n_fail++; $display("[TB] FAIL bad_ch2_pwm[%0d]: got %b expected 1", k, pwm_out[2]); end
        end
    endtask

    task automatic test_prescaler();
        logic r, e, found, exp_p, exp_c;
        presc = 8'd3;
        write_cfg(0, 1'b1, 1'b0, 4, 2, r, e);
        n_checks++;
        if (r !== 1'b1) begin n_fail++; $display("[TB] FAIL presc_ready: got %b expected 1", r); end
        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            @(negedge clk);
            if (cycle_start[0] && cfg_ready) found = 1'b1;
        end
        n_checks++;
        if (found !== 1'b1) begin n_fail++; $display("[TB] FAIL presc_commit: got no commit expected commit within 200 clk"); end
        if (found) begin
            for (int j = 1; j <= 28; j++) begin
                @(negedge clk);
                exp_p = (j <= 8) || (j >= 17 && j <= 22) || (j >= 27);
                exp_c = (j == 16) || (j == 26);
                n_checks++;
                if (pwm_out[0] !== exp_p) begin n_fail++; $display("[TB] FAIL presc_pwm[%0d]: got %b expected %b", j, pwm_out[0], exp_p); end
                n_checks++;
                if (cycle_start[0] !== exp_c) begin n_fail++; $display("[TB] FAIL presc_cs[%0d]: got %b expected %b", j, cycle_start[0], exp_c); end
                if (j == 16) presc = 8'd1;
            end
        end
        presc = 8'd0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_center_and_reset();
        logic r, e, found, exp_p, exp_c;
        write_cfg(1, 1'b1, 1'b1, 4, 2, r, e);
        n_checks++;
        if (e !== 1'b0) begin n_fail++; $display("[TB] FAIL ctr_err: got %b expected 0", e); end
        found = 1'b0;
        for (int t = 0; t < 50 && !found; t++) begin
            @(negedge clk);
            if (cycle_start[1] && cfg_ready) found = 1'b1;
        end
        n_checks++;
        if (found !== 1'b1) begin n_fail++; $display("[TB] FAIL ctr_commit: got no commit expected commit within 50 clk"); end
        if (found) begin
            for (int k = 1; k <= 17; k++) begin
                @(negedge clk);
`ifdef PWM_CENTER_EN
                exp_p = ((k % 8) <= 2);
                exp_c = ((k % 8) == 0);
`else
                exp_p = ((k % 4) == 1) || ((k % 4) == 2);
                exp_c = ((k % 4) == 0);
`endif
                n_checks++;
                if (pwm_out[1] !== exp_p) begin n_fail++; $display("[TB] FAIL ctr_pwm[%0d]: got %b expected %b", k, pwm_out[1], exp_p); end
                n_checks++;
                if (cycle_start[1] !== exp_c) begin n_fail++; $display("[TB] FAIL ctr_cs[%0d]: got %b expected %b", k, cycle_start[1], exp_c); end
                if (k == 17) begin
                    n_checks++;
                    if (cfg_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL ctr_pending: got ready %b expected 0", cfg_ready); end
                    cfg_valid = 1'b0;
                end
                if (k == 16) begin
                    cfg_ch     = CH_W'(1);
                    cfg_en     = 1'b1;
                    cfg_center = 1'b0;
                    cfg_period = CNT_W'(4);
                    cfg_duty   = CNT_W'(4);
                    cfg_valid  = 1'b1;
                end
            end
        end
        cfg_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (pwm_out !== 3'b000) begin n_fail++; $display("[TB] FAIL rst_async_pwm: got %b expected 000", pwm_out); end
        n_checks++;
        if (cycle_start !== 3'b000) begin n_fail++; $display("[TB] FAIL rst_async_cs: got %b expected 000", cycle_start); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cfg_ch = CH_W'(1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (pwm_out !== 3'b000) begin n_fail++; $display("[TB] FAIL rst_lost_pwm[%0d]: got %b expected 000", k, pwm_out); end
            n_checks++;
            if (cycle_start !== 3'b000) begin n_fail++; $display("[TB] FAIL rst_lost_cs[%0d]: got %b expected 000", k, cycle_start); end
        end
        n_checks++;
        if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_lost_ready: got %b expected 1", cfg_ready); end
    endtask

    initial begin
        rst        = 1'b1;
        presc      = '0;
        cfg_valid  = 1'b0;
        cfg_ch     = '0;
        cfg_en     = 1'b0;
        cfg_center = 1'b0;
        cfg_period = '0;
        cfg_duty   = '0;
        test_reset();
        test_edge_basic();
        test_duty_update();
        test_duty_limits();
        test_bad_channel();
        test_prescaler();
        test_center_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got time %0t expected end before 200000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
